// File: rtl/multdiv_ctrl.sv
`timescale 1ns/1ps
// Sequencer for the iterative multiply/divide unit: decodes mul/div in execute, pulses a start,
// stalls the pipeline until the unit answers or times out, then issues a one-cycle writeback.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT     = 40,
    parameter int unsigned RSTATUS_REG = 30,
    parameter int unsigned MUL_STATUS  = 4,
    parameter int unsigned DIV_STATUS  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [4:0]  opcode,
    input  logic [4:0]  ALUop,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        md_mult,
    output logic        md_div,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic [1:0]  state_dbg
);

    localparam logic [5:0]  LIMIT   = 6'(TIMEOUT - 1);
    localparam logic [4:0]  RS_IDX  = 5'(RSTATUS_REG);
    localparam logic [31:0] MUL_ST  = 32'(MUL_STATUS);
    localparam logic [31:0] DIV_ST  = 32'(DIV_STATUS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic        op_mul;
    logic [4:0]  rd;
    logic [5:0]  cnt;

    logic is_mul, is_div, start, finish, fin_err;

    assign is_mul = (opcode == 5'b00000) && (ALUop == 5'b00110);
    assign is_div = (opcode == 5'b00000) && (ALUop == 5'b00111);
    // Gated by reset so stall stays low while reset is held.
    assign start  = reset & valid_in & (is_mul | is_div) & ~flush & (state == IDLE);

    // md_ready takes priority over the timeout when both land in the same WAIT cycle.
    assign finish  = (state == WAIT) & ~flush & (md_ready | (cnt == LIMIT));
    assign fin_err = md_ready ? md_exception : 1'b1;

    assign md_mult   = (state == ISSUE) & op_mul  & ~flush;
    assign md_div    = (state == ISSUE) & ~op_mul & ~flush;
    assign stall     = start | (state == ISSUE) | (state == WAIT);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_mul   <= 1'b0;
            rd       <= 5'd0;
            cnt      <= 6'd0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            wb_err   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_mul <= is_mul;
                        rd     <= rd_in;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 6'd0;
                    state <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (finish) begin
                        state    <= DONE;
                        wb_err   <= fin_err;
                        wb_rd    <= fin_err ? RS_IDX : rd;
                        wb_data  <= fin_err ? (op_mul ? MUL_ST : DIV_ST) : md_result;
                        // A successful write to r0 still passes through DONE, silently.
                        wb_valid <= fin_err | (rd != 5'd0);
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
`timescale 1ns/1ps
// Bench for multdiv_ctrl: directed scenarios plus randomized ops, checked per cycle against a
// cycle-count model of accept/issue/wait/writeback built from the timing rules.
module tb_multdiv_ctrl;

    localparam int TO = 40;
    localparam logic [4:0]  RS = 5'd30;
    localparam logic [31:0] MS = 32'd4;
    localparam logic [31:0] DS = 32'd5;

    logic        clock, reset, valid_in, flush, md_exception, md_ready;
    logic [4:0]  opcode, ALUop, rd_in;
    logic [31:0] md_result;
    logic        md_mult, md_div, stall, busy, wb_valid, wb_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] exp_q[$];

    multdiv_ctrl #(.TIMEOUT(TO), .RSTATUS_REG(30), .MUL_STATUS(4), .DIV_STATUS(5)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .opcode(opcode), .ALUop(ALUop),
        .rd_in(rd_in), .flush(flush), .md_result(md_result), .md_exception(md_exception),
        .md_ready(md_ready), .md_mult(md_mult), .md_div(md_div), .stall(stall), .busy(busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; opcode = 5'd0; ALUop = 5'd0; rd_in = 5'd0; flush = 1'b0;
        md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    endtask

    // One mul/div op accepted at relative cycle 0. ready_d: md_ready at cycle 2+ready_d
    // (-1 = never). flush_i: cycle flush is raised (-1 = never).
    task automatic run_op(input string name, input bit mul, input logic [4:0] rd,
                          input int ready_d, input bit exc, input logic [31:0] res,
                          input int flush_i);
        bit rdy_ok, aborted, err;
        int c, endc, last;
        logic [37:0] e;
        rdy_ok  = (ready_d >= 0) && (ready_d < TO);
        c       = rdy_ok ? 2 + ready_d : 1 + TO;   // last WAIT cycle
        aborted = (flush_i >= 1) && (flush_i <= c);
        err     = rdy_ok ? exc : 1'b1;
        endc    = aborted ? flush_i : c + 1;
        last    = endc + 1;
        if (ready_d >= 0 && 3 + ready_d > last) last = 3 + ready_d;
        if (!aborted)
            exp_q.push_back({err, err ? RS : rd, err ? (mul ? MS : DS) : res});
        for (int i = 0; i <= last; i++) begin
            valid_in     = (i == 0);
            opcode       = 5'd0;
            ALUop        = mul ? 5'd6 : 5'd7;
            rd_in        = rd;
            flush        = (i == flush_i);
            md_ready     = (ready_d >= 0) && (i == 2 + ready_d);
            md_exception = md_ready ? exc : 1'($urandom);
            md_result    = md_ready ? res : $urandom;
            #1;
            check($sformatf("%s.stall@%0d", name, i), 32'(stall),
                  32'((i == 0) || (aborted ? (i <= flush_i) : (i <= c))));
            check($sformatf("%s.busy@%0d", name, i), 32'(busy), 32'((i >= 1) && (i <= endc)));
            check($sformatf("%s.md_mult@%0d", name, i), 32'(md_mult),
                  32'((i == 1) && mul && (flush_i != 1)));
            check($sformatf("%s.md_div@%0d", name, i), 32'(md_div),
                  32'((i == 1) && !mul && (flush_i != 1)));
            check($sformatf("%s.wb_valid@%0d", name, i), 32'(wb_valid),
                  32'(!aborted && (i == c + 1) && (err || rd != 5'd0)));
            if (!aborted && i == c + 1) begin
                e = exp_q.pop_front();
                check({name, ".wb_err"},  32'(wb_err), 32'(e[37]));
                check({name, ".wb_rd"},   32'(wb_rd),  32'(e[36:32]));
                check({name, ".wb_data"}, wb_data,     e[31:0]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    // A non-mul/div instruction must neither stall nor pulse.
    task automatic run_nonmd(input string name, input logic [4:0] opc, input logic [4:0] alu);
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1; opcode = opc; ALUop = alu; rd_in = 5'd3;
            #1;
            check($sformatf("%s.stall@%0d", name, i), 32'(stall), 32'd0);
            check($sformatf("%s.busy@%0d", name, i),  32'(busy),  32'd0);
            check($sformatf("%s.pulse@%0d", name, i), 32'(md_mult | md_div), 32'd0);
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        int r, fl;
        logic [4:0] opc, alu;
        idle_inputs();
        reset = 1'b0;
        #12;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.pulse", 32'(md_mult | md_div), 32'd0);
        check("rst.wb_valid", 32'(wb_valid), 32'd0);
        check("rst.wb_err", 32'(wb_err), 32'd0);
        check("rst.wb_rd", 32'(wb_rd), 32'd0);
        check("rst.wb_data", wb_data, 32'd0);
        check("rst.state", 32'(state_dbg), 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        run_op("mul_ok",     1'b1, 5'd5, 2,  1'b0, 32'h0000002A, -1);
        run_op("div_zero",   1'b0, 5'd7, 1,  1'b1, 32'hDEADBEEF, -1);
        run_op("timeout",    1'b1, 5'd9, -1, 1'b0, 32'h0,        -1);
        run_op("late_ready", 1'b1, 5'd9, 39, 1'b0, 32'h12345678, -1);
        run_op("div_timeout",1'b0, 5'd2, -1, 1'b0, 32'h0,        -1);
        run_op("flush_wait", 1'b1, 5'd4, 3,  1'b0, 32'h55,       3);
        run_op("flush_issue",1'b0, 5'd4, 1,  1'b0, 32'h66,       1);
        run_nonmd("add", 5'd0, 5'd0);
        run_nonmd("op_nz", 5'd8, 5'd6);
        run_op("rd_zero",    1'b1, 5'd0, 2,  1'b0, 32'h77,       -1);
        run_op("min_lat",    1'b0, 5'd11, 0, 1'b0, 32'hCAFE0001, -1);

        // async reset in the middle of WAIT
        run_op("pre_rst", 1'b1, 5'd12, 0, 1'b0, 32'hABCD, -1);
        valid_in = 1'b1; opcode = 5'd0; ALUop = 5'd6; rd_in = 5'd13;
        next_cycle();
        valid_in = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst.stall", 32'(stall), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.pulse", 32'(md_mult | md_div), 32'd0);
        check("arst.wb_valid", 32'(wb_valid), 32'd0);
        check("arst.wb_rd", 32'(wb_rd), 32'd0);
        check("arst.wb_data", wb_data, 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        run_op("post_rst", 1'b1, 5'd14, 2, 1'b0, 32'h0BADF00D, -1);

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                opc = 5'($urandom_range(0, 31));
                alu = 5'($urandom_range(0, 31));
                if (opc == 5'd0 && (alu == 5'd6 || alu == 5'd7)) alu = 5'd1;
                run_nonmd($sformatf("rnd%0d_nonmd", k), opc, alu);
            end else begin
                r  = $urandom_range(0, 45);
                fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : -1;
                run_op($sformatf("rnd%0d", k), 1'($urandom), 5'($urandom_range(0, 31)),
                       (r > 42) ? -1 : r, ($urandom_range(0, 3) == 0), $urandom, fl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the processor's iterative multiply/divide unit. It decodes `mul`/`div` in execute, pulses a start into the multdiv datapath, and stalls the upstream pipeline until the unit reports ready or a timeout fires. It then issues a one-cycle writeback. On exception or timeout it writes the status code to `$rstatus` instead of `rd`.

## Interface
- `TIMEOUT`, 40: maximum WAIT cycles before forced error completion (2..63)
- `RSTATUS_REG`, 30: register index for `$rstatus`
- `MUL_STATUS`, 4: status value for `mul` exception or timeout
- `DIV_STATUS`, 5: status value for `div` exception or timeout

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `valid_in`  in  1  execute-stage instruction valid
- `opcode`  in  5  instruction opcode
- `ALUop`  in  5  R-type ALU op field
- `rd_in`  in  5  destination register
- `flush`  in  1  squash the in-flight op (branch/jump)
- `md_result`  in  32  multdiv result
- `md_exception`  in  1  multdiv exception (overflow or divide-by-zero), valid with `md_ready`
- `md_ready`  in  1  multdiv result valid, one-cycle pulse
- `md_mult`  out  1  one-cycle multiply start pulse
- `md_div`  out  1  one-cycle divide start pulse
- `stall`  out  1  freeze PC, F/D and D/X latches
- `busy`  out  1  FSM not in IDLE
- `wb_valid`  out  1  writeback strobe, one cycle
- `wb_rd`  out  5  writeback register index
- `wb_data`  out  32  writeback data
- `wb_err`  out  1  writeback is a status write

## Operation
- Decode:
  - `is_mul` = `opcode==00000` and `ALUop==00110`.
  - `is_div` = `opcode==00000` and `ALUop==00111`.
  - `start` = `valid_in & (is_mul|is_div) & ~flush & state==IDLE`.
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - On `start`, latch `op` (mul/div) and `rd_in`, then go to ISSUE.
  - Otherwise stay in IDLE.
  - `md_ready` is ignored.
- ISSUE:
  - Drive `md_mult=op_mul&~flush` or `md_div=op_div&~flush` combinationally.
  - Clear the WAIT counter.
  - `flush` → IDLE. Otherwise → WAIT.
- WAIT:
  - Counter increments each cycle.
  - `flush` → IDLE, with no writeback.
  - `md_ready` → DONE, capturing result and exception.
  - Counter `==TIMEOUT-1` without `md_ready` → DONE with a forced error.
  - If `md_ready` and the limit occur in the same cycle, `md_ready` wins.
- DONE:
  - `wb_valid=1` for exactly one cycle, then → IDLE. `flush` is ignored in DONE.
- Writeback values captured on WAIT→DONE:
  - Error (`md_exception` or timeout): `wb_rd=RSTATUS_REG`, `wb_data`=`MUL_STATUS` or `DIV_STATUS` zero-extended to 32 bits, `wb_err=1`.
  - Success: `wb_rd=rd`, `wb_data=md_result`, `wb_err=0`.
  - Success with `rd==0`: `wb_valid` is suppressed (0) in DONE. FSM still passes through DONE.
- `stall` = `start | (state != IDLE & state != DONE)`. It drops in DONE so the next instruction enters execute while writeback fires.
- `busy` = `state != IDLE`.
- A flushed op may leave the multdiv unit running. Its late `md_ready` is ignored. A new start pulse restarts the unit.

## Timing
- Reset (async, `reset=0`):
  - State IDLE, counter 0.
  - `md_mult`, `md_div`, `stall`, `busy`, `wb_valid`, `wb_err` = 0.
  - `wb_rd=0`, `wb_data=0`.
- Reset mid-operation aborts immediately, with no writeback and no pulse.
- Accept at cycle N (IDLE, `start=1`, `stall=1` combinationally).
- ISSUE at N+1: start pulse high for that cycle only.
- WAIT begins at N+2. If `md_ready` arrives at cycle k ≥ N+2, `wb_valid` is high at k+1.
- Minimum accept-to-writeback latency: 3 cycles.
- Timeout: the last WAIT cycle is N+1+TIMEOUT. Forced error writeback occurs at N+2+TIMEOUT.
- Back-to-back ops: DONE → IDLE costs one cycle. Next earliest accept is DONE+1.
- `wb_rd`, `wb_data` and `wb_err` hold their last captured values until the next capture.

## Test plan
- Multiply success:
  - Stimulus: `mul` with `rd_in=5`; `md_ready` at N+4, `md_result=0x0000002A`, `md_exception=0`.
  - Required: `md_mult` high only at N+1; `stall` high N..N+4; writeback at N+5 with `wb_rd=5`, `wb_data=0x2A`, `wb_err=0`.
- Divide-by-zero:
  - Stimulus: `div` with `rd_in=7`; `md_ready` and `md_exception` at N+3.
  - Required: `md_div` pulses at N+1; writeback at N+4 with `wb_rd=30`, `wb_data=5`, `wb_err=1`.
- Timeout:
  - Stimulus: `mul`, `TIMEOUT=40`, `md_ready` never asserted.
  - Required: writeback at N+42 with `wb_rd=30`, `wb_data=4`, `wb_err=1`. A `md_ready` pulse at N+41 instead yields a normal writeback at N+42.
- Flush:
  - Stimulus: `flush` in WAIT at N+3, then `md_ready` at N+5.
  - Required: IDLE at N+4, no `wb_valid`, stall low from N+4.
  - Stimulus: `flush` in ISSUE.
  - Required: no start pulse.
- Decode and `rd=0`:
  - Stimulus: `add` (`ALUop=00000`) with `valid_in=1`.
  - Required: no stall, no pulse.
  - Stimulus: `mul` with `rd_in=0` succeeding.
  - Required: DONE visited with `busy=1`, `wb_valid=0`.
- Async reset mid-WAIT:
  - Stimulus: assert `reset=0` during WAIT.
  - Required: all outputs 0 immediately, without waiting for a clock edge; after release, the next `mul` is accepted normally.
